// File: rtl/ysyx_22050598_cache_miss_ctrl_pkg.sv
// Shared types and constants for the cache lookup/miss controller.
// State encoding, way width and a lowest-set-bit helper.
package ysyx_22050598_cache_miss_ctrl_pkg;

  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  localparam int DEF_IDX_W = 6;
  localparam int DEF_TAG_W = 21;
  localparam int DEF_OFF_W = 5;
  localparam int DEF_BEATS = 4;

  typedef logic [WAY_W-1:0] way_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
    RF_REQ  = 3'd4,
    RF_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  function automatic way_t first_one(
    input logic [WAYS-1:0] v
  );
    way_t w;
    w = '0;
    priority case (1'b1)
      v[0]:    w = 2'd0;
      v[1]:    w = 2'd1;
      v[2]:    w = 2'd2;
      v[3]:    w = 2'd3;
      default: w = 2'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ysyx_22050598_cache_miss_ctrl_if.sv
// Bus bundle between the miss controller and tag/LRU/memory side.
// master: the controller; slave: the surrounding cache.
interface ysyx_22050598_cache_miss_ctrl_if
  import ysyx_22050598_cache_miss_ctrl_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int BEATS = DEF_BEATS,
  parameter int ADDR_W = TAG_W + IDX_W + OFF_W,
  parameter int CNT_W = $clog2(BEATS)
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [IDX_W-1:0]  req_index_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic [WAYS-1:0]   tag_hit_i;
  logic [WAYS-1:0]   way_valid_i;
  logic [WAYS-1:0]   way_dirty_i;
  logic [WAYS*TAG_W-1:0] way_tag_i;
  way_t              lru_victim_i;
  logic [IDX_W-1:0]  lru_set_o;
  logic              lru_wen_o;
  way_t              lru_way_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic              wb_done_i;
  logic [ADDR_W-1:0] wb_addr_o;
  logic              rf_valid_o;
  logic              rf_ready_i;
  logic              rf_dvalid_i;
  logic [ADDR_W-1:0] rf_addr_o;
  logic              refill_we_o;
  logic [CNT_W-1:0]  refill_beat_o;
  logic              tag_we_o;
  logic              resp_valid_o;
  logic              resp_hit_o;
  way_t              resp_way_o;

  modport master (
    input  req_valid_i, req_index_i, req_tag_i,
    input  tag_hit_i, way_valid_i, way_dirty_i,
    input  way_tag_i, lru_victim_i,
    input  wb_ready_i, wb_done_i,
    input  rf_ready_i, rf_dvalid_i,
    output req_ready_o, lru_set_o, lru_wen_o,
    output lru_way_o, wb_valid_o, wb_addr_o,
    output rf_valid_o, rf_addr_o,
    output refill_we_o, refill_beat_o,
    output tag_we_o, resp_valid_o,
    output resp_hit_o, resp_way_o
  );

  modport slave (
    output req_valid_i, req_index_i, req_tag_i,
    output tag_hit_i, way_valid_i, way_dirty_i,
    output way_tag_i, lru_victim_i,
    output wb_ready_i, wb_done_i,
    output rf_ready_i, rf_dvalid_i,
    input  req_ready_o, lru_set_o, lru_wen_o,
    input  lru_way_o, wb_valid_o, wb_addr_o,
    input  rf_valid_o, rf_addr_o,
    input  refill_we_o, refill_beat_o,
    input  tag_we_o, resp_valid_o,
    input  resp_hit_o, resp_way_o
  );

endinterface

// File: rtl/ysyx_22050598_cache_victim_sel.sv
// Combinational way picker: hit way, else first invalid way,
// else the LRU victim.
module ysyx_22050598_cache_victim_sel
  import ysyx_22050598_cache_miss_ctrl_pkg::*;
(
  input  logic [WAYS-1:0] tag_hit,
  input  logic [WAYS-1:0] way_valid,
  input  way_t            lru_victim,
  output logic            hit,
  output way_t            hit_way,
  output way_t            victim
);

  logic [WAYS-1:0] hits;

  assign hits    = tag_hit & way_valid;
  assign hit     = |hits;
  assign hit_way = first_one(hits);
  assign victim  = (&way_valid) ? lru_victim
                                : first_one(~way_valid);

endmodule

// File: rtl/ysyx_22050598_cache_miss_ctrl.sv
// Lookup/miss controller for the 4-way set-associative cache:
// promote on hit, writeback + refill + tag write on miss.
module ysyx_22050598_cache_miss_ctrl
  import ysyx_22050598_cache_miss_ctrl_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int BEATS = DEF_BEATS
)(
  input logic clk,
  input logic rst,
  ysyx_22050598_cache_miss_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(BEATS);

  state_t state, next;

  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  way_t             vic_q;
  logic [TAG_W-1:0] vic_tag_q;
  logic [CNT_W-1:0] cnt_q;

  logic hit;
  way_t hit_way;
  way_t victim;
  logic vic_dirty;
  logic [TAG_W-1:0] tags [WAYS];

  ysyx_22050598_cache_victim_sel u_sel (
    .tag_hit    (bus.tag_hit_i),
    .way_valid  (bus.way_valid_i),
    .lru_victim (bus.lru_victim_i),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim     (victim)
  );

  always_comb begin
    for (int w = 0; w < WAYS; w++)
      tags[w] = bus.way_tag_i[w*TAG_W +: TAG_W];
  end

  assign vic_dirty = bus.way_valid_i[victim]
                   & bus.way_dirty_i[victim];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:
        if (bus.req_valid_i) next = LOOKUP;
      LOOKUP:
        if (hit)            next = IDLE;
        else if (vic_dirty) next = WB_REQ;
        else                next = RF_REQ;
      WB_REQ:
        if (bus.wb_ready_i)
          next = bus.wb_done_i ? RF_REQ : WB_WAIT;
      WB_WAIT:
        if (bus.wb_done_i) next = RF_REQ;
      RF_REQ:
        if (bus.rf_ready_i) next = RF_DATA;
      RF_DATA:
        if (bus.rf_dvalid_i
            && cnt_q == CNT_W'(BEATS-1))
          next = DONE;
      DONE:
        next = IDLE;
      default:
        next = IDLE;
    endcase
  end

  // Request and victim latches plus beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      tag_q     <= '0;
      vic_q     <= '0;
      vic_tag_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (state == IDLE && bus.req_valid_i) begin
        idx_q <= bus.req_index_i;
        tag_q <= bus.req_tag_i;
      end
      if (state == LOOKUP && !hit) begin
        vic_q     <= victim;
        vic_tag_q <= tags[victim];
      end
      if (state == RF_REQ)
        cnt_q <= '0;
      else if (state == RF_DATA && bus.rf_dvalid_i)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  logic lk_hit;
  logic done;

  assign lk_hit = (state == LOOKUP) && hit;
  assign done   = (state == DONE);

  always_comb begin
    bus.req_ready_o   = (state == IDLE);
    bus.lru_set_o     = idx_q;
    bus.lru_wen_o     = lk_hit | done;
    bus.lru_way_o     = '0;
    bus.resp_way_o    = '0;
    bus.resp_valid_o  = lk_hit | done;
    bus.resp_hit_o    = lk_hit;
    bus.tag_we_o      = done;
    bus.wb_valid_o    = (state == WB_REQ);
    bus.wb_addr_o     = {vic_tag_q, idx_q, OFF_W'(0)};
    bus.rf_valid_o    = (state == RF_REQ);
    bus.rf_addr_o     = {tag_q, idx_q, OFF_W'(0)};
    bus.refill_we_o   = (state == RF_DATA)
                      & bus.rf_dvalid_i;
    bus.refill_beat_o = cnt_q;
    if (lk_hit) begin
      bus.lru_way_o  = hit_way;
      bus.resp_way_o = hit_way;
    end else if (done) begin
      bus.lru_way_o  = vic_q;
      bus.resp_way_o = vic_q;
    end
  end

endmodule
